cpu_bus_fabric: RTL
===================

Name: cpu_bus_fabric

Overview:
Parametrised successor to the fixed top-level CPU memory decode mux. It sits between the picorv32 memory interface and NUM_SLOTS target cores. It decodes cpu_addr[31:24] against a per-slot prefix table and drives one-hot chip selects. It returns a registered ready/rdata and adds capabilities the fixed mux lacks: multi-cycle wait handling, a target timeout, system-mode-only slot protection and a bus-error pulse.

Parameters:
NUM_SLOTS, 8, number of target slots (1..16)
SLOT_PREFIXES, {8{8'h00}}, flat NUM_SLOTS*8 vector; slot i matches when cpu_addr[31:24] == SLOT_PREFIXES[i*8+:8]
SLOT_SYS_ONLY, 8'h00, NUM_SLOTS-bit mask; set bit = slot accessible only when system_mode=1
TGT_ADDR_W, 16, word-address width sent to targets
TIMEOUT_CYCLES, 255, maximum wait cycles before error (1..255)
ERR_RDATA, 32'h0, read data returned on decode, protection or timeout error
TRAP_RDATA, 32'h0, read data returned when force_trap is asserted (illegal instruction)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cpu_valid  in  1  picorv32 mem_valid
cpu_addr  in  32  byte address
cpu_wstrb  in  4  byte write strobes; 0 = read
cpu_wdata  in  32  write data
cpu_ready  out  1  registered one-cycle response strobe
cpu_rdata  out  32  registered read data
force_trap  in  1  substitute TRAP_RDATA for the current access
system_mode  in  1  1 = firmware mode; 0 = application mode
tgt_cs  out  NUM_SLOTS  one-hot chip selects
tgt_we  out  4  = cpu_wstrb, shared by all slots
tgt_address  out  TGT_ADDR_W  = cpu_addr[TGT_ADDR_W+1:2]
tgt_wdata  out  32  = cpu_wdata
tgt_rdata  in  NUM_SLOTS*32  flat read data; slot i at [i*32+:32]
tgt_ready  in  NUM_SLOTS  per-slot ready
bus_err  out  1  one-cycle pulse coincident with an error response

Behaviour:
- Reset values: state=IDLE, cpu_ready=0, cpu_rdata=0, bus_err=0, wait_cnt=0, tgt_cs=0.
- Decode: the lowest-index matching slot wins when prefixes duplicate. No match = decode error.
- Protection: if the matched slot has SLOT_SYS_ONLY set and system_mode=0, it is a protection error and tgt_cs stays low.
- FSM with states IDLE, WAIT and RESP.
- IDLE, when cpu_valid=1:
  - force_trap=1 → latch TRAP_RDATA; go to RESP. Highest priority; bus_err stays 0.
  - Decode or protection error → latch ERR_RDATA, set bus_err; go to RESP.
  - Legal access → drive tgt_cs[slot]=1 combinationally in the same cycle.
    - tgt_ready[slot]=1 → latch tgt_rdata[slot]; go to RESP. cpu_ready rises on the next edge (1-cycle latency).
    - Otherwise → go to WAIT with wait_cnt=1.
- WAIT:
  - tgt_cs[slot] stays high, with the slot latched at entry to WAIT.
  - tgt_ready → latch rdata; go to RESP.
  - Otherwise wait_cnt increments. At wait_cnt==TIMEOUT_CYCLES with no ready → ERR_RDATA and bus_err; go to RESP.
  - cpu_valid dropping in WAIT → abort to IDLE with no cpu_ready and no error.
- RESP:
  - cpu_ready=1 and cpu_rdata are valid for exactly one cycle; tgt_cs=0.
  - bus_err=1 if the response is an error.
  - Next state is IDLE unconditionally.
  - A new access is accepted no earlier than the cycle after RESP, giving at least 2 cycles per access.
- Writes follow the same path; cpu_rdata on write responses carries whatever was selected, and software ignores it.
- tgt_ready from unselected slots is ignored.
- Reset asserted mid-access → all state returns to reset values on that edge; no response is issued.

Optional Feature:
CPU_BUS_FABRIC_TIMEOUT_EN:
- Defined: wait_cnt and timeout error are present as described above.
- Undefined: the counter logic is omitted. WAIT holds indefinitely until tgt_ready or cpu_valid drops. TIMEOUT_CYCLES is unused, and bus_err fires only on decode or protection errors.

Decomposition:
- Package cpu_bus_pkg holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Existing core prefix constants (ROM 8'h00, FW_RAM 8'hD0, TRNG 8'hC0, TIMER 8'hC1, UART 8'hC3, BLAKE2S 8'hD9, CK1 8'hFF).
  - Width constants.
- Sub-module cpu_bus_slot_decode (combinational): prefix table + cpu_addr[31:24] + system_mode → one-hot hit, hit_valid, prot_err. It is instantiated once.

Test Plan:
- Slot 2 prefix 8'hC3 with tgt_ready tied high; read 0xC300_0010 → tgt_cs=8'b0000_0100 and tgt_address=4; cpu_ready one cycle later with rdata=tgt_rdata[95:64]=32'h1234_5678.
- Slot 1 asserts ready after 5 cycles → tgt_cs held for 6 cycles, one cpu_ready pulse, correct rdata, bus_err=0.
- Read 0x8000_0000 with no matching prefix → cpu_ready after 1 cycle, rdata=ERR_RDATA, bus_err pulse, tgt_cs=0 throughout.
- SLOT_SYS_ONLY[4]=1; access slot 4 with system_mode=0 → protection error and bus_err; repeat with system_mode=1 → normal response.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, a target that never asserts ready → error response after exactly 8 WAIT cycles; without the macro, still waiting at cycle 100.
- force_trap=1 on an access to a valid slot → rdata=TRAP_RDATA, tgt_cs=0, bus_err=0. Separately, reset asserted in WAIT → cpu_ready never pulses and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU bus fabric: FSM encoding, core address prefixes
// and bus widths.
package cpu_bus_pkg;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int WSTRB_W   = 4;
   localparam int PREFIX_W  = 8;
   localparam int CNT_W     = 8;
   localparam int MAX_SLOTS = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } bus_state_t;

   // cpu_addr[31:24] prefixes of the cores already on the bus
   localparam logic [PREFIX_W-1:0] PFX_ROM     = 8'h00;
   localparam logic [PREFIX_W-1:0] PFX_FW_RAM  = 8'hD0;
   localparam logic [PREFIX_W-1:0] PFX_TRNG    = 8'hC0;
   localparam logic [PREFIX_W-1:0] PFX_TIMER   = 8'hC1;
   localparam logic [PREFIX_W-1:0] PFX_UART    = 8'hC3;
   localparam logic [PREFIX_W-1:0] PFX_BLAKE2S = 8'hD9;
   localparam logic [PREFIX_W-1:0] PFX_CK1     = 8'hFF;

endpackage

// File: rtl/cpu_bus_slot_decode.sv
// Address prefix decoder: one-hot slot hit (lowest index wins on duplicate
// prefixes) plus a protection flag for system-only slots.
module cpu_bus_slot_decode
   import cpu_bus_pkg::*;
#(
   parameter int                      NUM_SLOTS     = 8,
   parameter logic [NUM_SLOTS*8-1:0]  SLOT_PREFIXES = '0,
   parameter logic [NUM_SLOTS-1:0]    SLOT_SYS_ONLY = '0
) (
   input  logic [PREFIX_W-1:0]  addr_prefix,
   input  logic                 system_mode,
   output logic [NUM_SLOTS-1:0] hit,
   output logic                 hit_valid,
   output logic                 prot_err
);

   always_comb begin
      hit       = '0;
      hit_valid = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!hit_valid && (addr_prefix == SLOT_PREFIXES[i*PREFIX_W +: PREFIX_W])) begin
            hit[i]    = 1'b1;
            hit_valid = 1'b1;
         end
      end
   end

   assign prot_err = hit_valid && !system_mode && (|(hit & SLOT_SYS_ONLY));

endmodule

// File: rtl/cpu_bus_fabric.sv
// picorv32 memory bus fabric: prefix decode, one-hot chip selects, registered
// response. Define CPU_BUS_FABRIC_TIMEOUT_EN to enable the wait-state timeout.
module cpu_bus_fabric
   import cpu_bus_pkg::*;
#(
   parameter int                      NUM_SLOTS      = 8,
   parameter logic [NUM_SLOTS*8-1:0]  SLOT_PREFIXES  = '0,
   parameter logic [NUM_SLOTS-1:0]    SLOT_SYS_ONLY  = '0,
   parameter int                      TGT_ADDR_W     = 16,
   parameter int                      TIMEOUT_CYCLES = 255,
   parameter logic [31:0]             ERR_RDATA      = 32'h0,
   parameter logic [31:0]             TRAP_RDATA     = 32'h0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cpu_valid,
   input  logic [31:0]             cpu_addr,
   input  logic [3:0]              cpu_wstrb,
   input  logic [31:0]             cpu_wdata,
   output logic                    cpu_ready,
   output logic [31:0]             cpu_rdata,
   input  logic                    force_trap,
   input  logic                    system_mode,
   output logic [NUM_SLOTS-1:0]    tgt_cs,
   output logic [3:0]              tgt_we,
   output logic [TGT_ADDR_W-1:0]   tgt_address,
   output logic [31:0]             tgt_wdata,
   input  logic [NUM_SLOTS*32-1:0] tgt_rdata,
   input  logic [NUM_SLOTS-1:0]    tgt_ready,
   output logic                    bus_err
);

   if (NUM_SLOTS < 1 || NUM_SLOTS > MAX_SLOTS || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
      $error("cpu_bus_fabric: NUM_SLOTS or TIMEOUT_CYCLES out of range");
   end

   bus_state_t           state, next_state;
   logic [NUM_SLOTS-1:0] hit, slot_q, slot_d, sel_mask;
   logic                 hit_valid, prot_err, sel_ready, timed_out;
   logic [31:0]          sel_rdata, rdata_q, rdata_d;
   logic                 ready_q, err_q, err_d;
   logic                 unused_addr_bits;

   cpu_bus_slot_decode #(
      .NUM_SLOTS     (NUM_SLOTS),
      .SLOT_PREFIXES (SLOT_PREFIXES),
      .SLOT_SYS_ONLY (SLOT_SYS_ONLY)
   ) u_decode (
      .addr_prefix (cpu_addr[31:24]),
      .system_mode (system_mode),
      .hit         (hit),
      .hit_valid   (hit_valid),
      .prot_err    (prot_err)
   );

   // Ready/rdata come only from the slot being served; other slots' ready is ignored.
   always_comb begin
      sel_mask  = (state == WAIT) ? slot_q : hit;
      sel_ready = |(sel_mask & tgt_ready);
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (sel_mask[i]) sel_rdata = sel_rdata | tgt_rdata[i*32 +: 32];
      end
   end

   // Handshake: the CPU holds cpu_valid until cpu_ready, which is a one-cycle
   // strobe; dropping cpu_valid while waiting abandons the access silently.
   always_comb begin
      next_state = state;
      tgt_cs     = '0;
      slot_d     = slot_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_valid) begin
               if (force_trap) begin
                  rdata_d    = TRAP_RDATA;
                  next_state = RESP;
               end else if (!hit_valid || prot_err) begin
                  rdata_d    = ERR_RDATA;
                  err_d      = 1'b1;
                  next_state = RESP;
               end else begin
                  tgt_cs = hit;
                  slot_d = hit;
                  if (sel_ready) begin
                     rdata_d    = sel_rdata;
                     next_state = RESP;
                  end else begin
                     next_state = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (!cpu_valid) begin
               next_state = IDLE;
            end else begin
               tgt_cs = slot_q;
               if (sel_ready) begin
                  rdata_d    = sel_rdata;
                  next_state = RESP;
               end else if (timed_out) begin
                  rdata_d    = ERR_RDATA;
                  err_d      = 1'b1;
                  next_state = RESP;
               end
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         slot_q  <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= next_state;
         slot_q  <= slot_d;
         rdata_q <= rdata_d;
         ready_q <= (next_state == RESP);
         err_q   <= err_d;
      end
   end

`ifdef CPU_BUS_FABRIC_TIMEOUT_EN
   logic [CNT_W-1:0] wait_cnt, wait_cnt_d;

   // wait_cnt is 1 on the first WAIT cycle, so the timeout spans TIMEOUT_CYCLES WAIT cycles.
   always_comb begin
      wait_cnt_d = '0;
      if (next_state == WAIT) wait_cnt_d = (state == WAIT) ? wait_cnt + 1'b1 : CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) wait_cnt <= '0;
      else          wait_cnt <= wait_cnt_d;
   end

   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
   assign timed_out = 1'b0;
`endif

   assign cpu_ready        = ready_q;
   assign cpu_rdata        = rdata_q;
   assign bus_err          = err_q;
   assign tgt_we           = cpu_wstrb;
   assign tgt_address      = cpu_addr[TGT_ADDR_W+1:2];
   assign tgt_wdata        = cpu_wdata;
   assign unused_addr_bits = ^{cpu_addr[31:TGT_ADDR_W+2], cpu_addr[1:0]};

endmodule
